// File: rtl/hier_pkg.sv
// rtl/hier_pkg.sv - shared constants, state encoding and width helper for the response collector
package hier_pkg;

    localparam int DEF_NUM_CHILD = 5;
    localparam int DEF_DATA_W    = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_REPORT  = 2'd2;

    // Aggregate width: enough headroom that summing every child word can never overflow.
    function automatic int sum_w(input int num_child, input int data_w);
        return data_w + $clog2(num_child + 1);
    endfunction

endpackage

// File: rtl/hier_resp_collector_rr_arbiter.sv
// rtl/hier_resp_collector_rr_arbiter.sv - round-robin one-hot grant starting at a pointer
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    int           pos;
    logic [IW-1:0] pos_idx;
    logic          found;

    // Scan requesters from ptr upward with wrap; the first one found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (!found && req[pos_idx]) begin
                found        = 1'b1;
                gnt[pos_idx] = 1'b1;
                gnt_idx      = pos_idx;
            end
        end
    end

endmodule

// File: rtl/hier_resp_collector.sv
// rtl/hier_resp_collector.sv - collects one word per child and reports the aggregate upstream
module hier_resp_collector
    import hier_pkg::*;
#(
    parameter int NUM_CHILD   = DEF_NUM_CHILD,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [NUM_CHILD-1:0]                child_valid_i,
    input  logic [NUM_CHILD*DATA_W-1:0]         child_data_i,
    output logic [NUM_CHILD-1:0]                child_ready_o,
    output logic                                up_valid_o,
    input  logic                                up_ready_i,
    output logic [sum_w(NUM_CHILD, DATA_W)-1:0] up_sum_o,
    output logic [NUM_CHILD-1:0]                up_mask_o,
    output logic                                up_err_o,
    output logic                                busy_o
);

    localparam int SUM_W = sum_w(NUM_CHILD, DATA_W);
    localparam int IW    = $clog2(NUM_CHILD);

    state_t               state_q;
    logic [SUM_W-1:0]     sum_q;
    logic [NUM_CHILD-1:0] mask_q;
    logic                 err_q;
    logic [15:0]          timer_q;
    logic [IW-1:0]        ptr_q;

    logic [NUM_CHILD-1:0] req;
    logic [NUM_CHILD-1:0] gnt;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        ptr_nxt;
    logic [NUM_CHILD-1:0] mask_acc;
    logic [DATA_W-1:0]    word;
    logic                 accept;

    // Children already collected this round are masked out of arbitration.
    assign req = child_valid_i & ~mask_q;

    rr_arbiter #(
        .N(NUM_CHILD)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign child_ready_o = (state_q == ST_COLLECT) ? gnt : '0;
    assign accept        = |child_ready_o;
    assign mask_acc      = mask_q | child_ready_o;
    assign ptr_nxt       = (gnt_idx == IW'(NUM_CHILD - 1)) ? '0 : gnt_idx + IW'(1);

    // Select the granted child's word; gnt is one-hot so at most one term is live.
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (gnt[i]) begin
                word = child_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign up_valid_o = (state_q == ST_REPORT);
    assign up_sum_o   = sum_q;
    assign up_mask_o  = mask_q;
    assign up_err_o   = err_q;
    assign busy_o     = (state_q != ST_IDLE);

    // Round FSM with timer, accumulator, mask and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_COLLECT;
                        sum_q   <= '0;
                        mask_q  <= '0;
                        err_q   <= 1'b0;
                        timer_q <= 16'(TIMEOUT_CYC);
                    end
                end
                ST_COLLECT: begin
                    timer_q <= timer_q - 16'd1;
                    if (accept) begin
                        sum_q  <= sum_q + SUM_W'(word);
                        mask_q <= mask_acc;
                        ptr_q  <= ptr_nxt;
                    end
                    // A full mask wins over expiry so a last-cycle completion is not an error.
                    if (&mask_acc) begin
                        state_q <= ST_REPORT;
                        err_q   <= 1'b0;
                    end else if (timer_q == 16'd1) begin
                        state_q <= ST_REPORT;
                        err_q   <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (up_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hier_resp_collector.sv
// tb/tb_hier_resp_collector.sv - randomized and directed rounds against a behavioural model
module tb_hier_resp_collector;
    import hier_pkg::*;

    localparam int NC = 5;
    localparam int DW = 16;
    localparam int TO = 10;
    localparam int SW = sum_w(NC, DW);
    localparam int NEVER = 100000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [NC-1:0]    child_valid_i;
    logic [NC*DW-1:0] child_data_i;
    logic [NC-1:0]    child_ready_o;
    logic             up_valid_o;
    logic             up_ready_i;
    logic [SW-1:0]    up_sum_o;
    logic [NC-1:0]    up_mask_o;
    logic             up_err_o;
    logic             busy_o;

    hier_resp_collector #(
        .NUM_CHILD  (NC),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .child_valid_i(child_valid_i),
        .child_data_i (child_data_i),
        .child_ready_o(child_ready_o),
        .up_valid_o   (up_valid_o),
        .up_ready_i   (up_ready_i),
        .up_sum_o     (up_sum_o),
        .up_mask_o    (up_mask_o),
        .up_err_o     (up_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: round results and the arbiter pointer carried across rounds.
    int            m_ptr;
    logic [31:0]   m_sum;
    logic [NC-1:0] m_mask;
    logic          m_err;

    // Per-round stimulus: valid window [vs, vs+vl) in collect-cycle numbers, and data words.
    int          vs[NC];
    int          vl[NC];
    logic [DW-1:0] wd[NC];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NC-1:0] elig, input int ptr);
        for (int k = 0; k < NC; k++) begin
            if (elig[(ptr + k) % NC]) return (ptr + k) % NC;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < NC; i++) child_data_i[i*DW +: DW] = wd[i];
    endtask

    task automatic run_round(input int rdy_delay, input bit start_hold, input bit dir,
                             input logic [31:0] dsum, input logic [NC-1:0] dmask, input logic derr);
        logic [NC-1:0] v;
        logic [NC-1:0] exp_gnt;
        int            g;
        int            c;
        bit            done;
        tick();
        start_i       = 1'b1;
        up_ready_i    = 1'b0;
        child_valid_i = NC'($urandom);
        load_data();
        #1;
        check_val("idle_busy", 32'(busy_o), 32'd0);
        check_val("idle_valid", 32'(up_valid_o), 32'd0);
        check_val("idle_ready", 32'(child_ready_o), 32'd0);
        check_val("idle_sum_hold", 32'(up_sum_o), m_sum);
        m_sum  = 0;
        m_mask = '0;
        m_err  = 1'b0;
        done   = 1'b0;
        c      = 0;
        while (!done) begin
            c++;
            tick();
            start_i = 1'($urandom);
            v = '0;
            for (int i = 0; i < NC; i++) if (c >= vs[i] && c < vs[i] + vl[i]) v[i] = 1'b1;
            child_valid_i = v;
            #1;
            g = model_pick(v & ~m_mask, m_ptr);
            exp_gnt = (g >= 0) ? (NC'(1) << g) : '0;
            check_val("col_ready", 32'(child_ready_o), 32'(exp_gnt));
            check_val("col_busy", 32'(busy_o), 32'd1);
            check_val("col_valid", 32'(up_valid_o), 32'd0);
            if (g >= 0) begin
                m_sum     = m_sum + 32'(wd[g]);
                m_mask[g] = 1'b1;
                m_ptr     = (g + 1) % NC;
            end
            if (&m_mask) done = 1'b1;
            else if (c == TO) begin
                done  = 1'b1;
                m_err = 1'b1;
            end
        end
        for (int r = 0; r <= rdy_delay; r++) begin
            tick();
            up_ready_i    = (r == rdy_delay);
            start_i       = start_hold ? 1'b1 : 1'($urandom);
            child_valid_i = NC'($urandom);
            #1;
            check_val("rep_valid", 32'(up_valid_o), 32'd1);
            check_val("rep_sum", 32'(up_sum_o), m_sum);
            check_val("rep_mask", 32'(up_mask_o), 32'(m_mask));
            check_val("rep_err", 32'(up_err_o), 32'(m_err));
            check_val("rep_ready", 32'(child_ready_o), 32'd0);
            check_val("rep_busy", 32'(busy_o), 32'd1);
            if (dir && r == 0) begin
                check_val("dir_sum", 32'(up_sum_o), dsum);
                check_val("dir_mask", 32'(up_mask_o), 32'(dmask));
                check_val("dir_err", 32'(up_err_o), 32'(derr));
            end
        end
        tick();
        up_ready_i = 1'b0;
        start_i    = 1'b0;
        #1;
        check_val("post_busy", 32'(busy_o), 32'd0);
        check_val("post_valid", 32'(up_valid_o), 32'd0);
        check_val("post_sum_hold", 32'(up_sum_o), m_sum);
    endtask

    initial begin
        logic [NC-1:0] exp_gnt;
        int            g;
        rst           = 1'b1;
        start_i       = 1'b0;
        up_ready_i    = 1'b0;
        child_valid_i = '0;
        child_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(child_ready_o), 32'd0);
        check_val("rst_valid", 32'(up_valid_o), 32'd0);
        check_val("rst_sum", 32'(up_sum_o), 32'd0);
        check_val("rst_mask", 32'(up_mask_o), 32'd0);
        check_val("rst_err", 32'(up_err_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        rst   = 1'b0;
        m_ptr = 0;
        m_sum = 0;

        // All valid, data 1..5: grants walk 0..4 and report arrives right after.
        for (int i = 0; i < NC; i++) begin vs[i] = 0; vl[i] = NEVER; wd[i] = DW'(i + 1); end
        run_round(0, 1'b0, 1'b1, 32'd15, 5'b11111, 1'b0);

        // Staggered arrivals 3,0,4,1,2 each 0x00FF.
        vs[3] = 1; vs[0] = 2; vs[4] = 3; vs[1] = 4; vs[2] = 5;
        for (int i = 0; i < NC; i++) begin vl[i] = NEVER; wd[i] = 16'h00FF; end
        run_round(1, 1'b0, 1'b1, 32'h04FB, 5'b11111, 1'b0);

        // Child 2 absent: timeout closes the round.
        for (int i = 0; i < NC; i++) begin vs[i] = 1; vl[i] = NEVER; wd[i] = 16'h1000; end
        vs[2] = NEVER;
        run_round(0, 1'b0, 1'b1, 32'h4000, 5'b11011, 1'b1);

        // Child 1 holds valid four cycles; only one accept.
        for (int i = 0; i < NC; i++) begin vs[i] = NEVER; vl[i] = 0; wd[i] = DW'($urandom); end
        vs[1] = 2; vl[1] = 4;
        run_round(0, 1'b0, 1'b1, 32'(wd[1]), 5'b00010, 1'b1);

        // Parent stalls seven cycles with start held high throughout report.
        for (int i = 0; i < NC; i++) begin vs[i] = 1; vl[i] = NEVER; wd[i] = DW'($urandom); end
        run_round(7, 1'b1, 1'b0, 32'd0, 5'b0, 1'b0);

        // Randomized rounds: random arrival times, hold lengths, data and backpressure.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NC; i++) begin
                vs[i] = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 12);
                vl[i] = ($urandom_range(0, 1) == 0) ? NEVER : $urandom_range(1, 6);
                wd[i] = DW'($urandom);
            end
            run_round($urandom_range(0, 3), 1'b0, 1'b0, 32'd0, 5'b0, 1'b0);
        end

        // Reset after two accepts mid-collect.
        for (int i = 0; i < NC; i++) begin vs[i] = 0; vl[i] = NEVER; wd[i] = DW'($urandom); end
        tick();
        start_i       = 1'b1;
        child_valid_i = '1;
        load_data();
        m_mask = '0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            start_i = 1'b0;
            #1;
            g = model_pick(child_valid_i & ~m_mask, m_ptr);
            exp_gnt = (g >= 0) ? (NC'(1) << g) : '0;
            check_val("mid_ready", 32'(child_ready_o), 32'(exp_gnt));
            if (g >= 0) begin
                m_mask[g] = 1'b1;
                m_ptr     = (g + 1) % NC;
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("mrst_ready", 32'(child_ready_o), 32'd0);
        check_val("mrst_valid", 32'(up_valid_o), 32'd0);
        check_val("mrst_sum", 32'(up_sum_o), 32'd0);
        check_val("mrst_mask", 32'(up_mask_o), 32'd0);
        check_val("mrst_busy", 32'(busy_o), 32'd0);
        m_ptr = 0;
        m_sum = 0;
        run_round(0, 1'b0, 1'b0, 32'd0, 5'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
